// File: rtl/cmd_cntrl.sv
// -----------------------------------------------------------------------------
// cmd_cntrl
//   Command controller sitting behind UART_rx and the barcode reader.
//   Each received command byte is acknowledged (clr_cmd_rdy) in the cycle it is
//   seen. The byte is decoded as opcode [7:6] plus station ID [5:0]:
//     01 = GO to station, 00 = STOP, 10/11 = ignored (still acknowledged).
//   While moving, barcode IDs are compared against the latched destination.
//   A match drops 'go' and pulses 'arrived' for one cycle.
//
//   Optional piezo buzzer: define CMD_CNTRL_BUZZ_EN.
//     Defined   : an arrival starts a BUZZ_LEN-cycle tone. During the tone,
//                 buzz toggles every BUZZ_DIV clocks. A new GO silences it.
//     Undefined : buzz is tied 0 and buzz_n is tied 1. The ports are kept.
//
// Ports
//   clk, rst_n   system clock; asynchronous active-low reset
//   cmd[7:0]     command byte from UART_rx
//   cmd_rdy      command valid, held by UART_rx until cleared
//   clr_cmd_rdy  1-cycle command acknowledge (combinational)
//   ID[7:0]      station ID from barcode reader ([7:6] must be 0)
//   ID_vld       ID valid, held by the reader until cleared
//   clr_ID_vld   1-cycle ID acknowledge (combinational)
//   go           registered motion enable
//   dest_ID[5:0] registered destination station
//   arrived      registered 1-cycle arrival pulse
//   buzz, buzz_n complementary piezo drive
// -----------------------------------------------------------------------------
module cmd_cntrl
`ifdef CMD_CNTRL_BUZZ_EN
#(
  parameter int unsigned BUZZ_DIV = 12500,
  parameter int unsigned BUZZ_LEN = 25000000
)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd,
  input  logic       cmd_rdy,
  output logic       clr_cmd_rdy,
  input  logic [7:0] ID,
  input  logic       ID_vld,
  output logic       clr_ID_vld,
  output logic       go,
  output logic [5:0] dest_ID,
  output logic       arrived,
  output logic       buzz,
  output logic       buzz_n
);

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_GO   = 2'b01;

  typedef enum logic {IDLE, MOVING} state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] stn;
  } cmd_t;

  cmd_t   cmd_d;
  state_t state, state_nxt;
  logic   go_nxt, arrived_nxt;
  logic   [5:0] dest_nxt;
  logic   ack_cmd, ack_id;

  assign cmd_d = cmd_t'(cmd);

  // Next-state and acknowledge decode. A pending command always takes
  // priority over a pending ID. The ID stays pending and is evaluated in the
  // next cycle against whatever destination the command left behind.
  always_comb begin
    state_nxt   = state;
    go_nxt      = go;
    dest_nxt    = dest_ID;
    arrived_nxt = 1'b0;
    ack_cmd     = 1'b0;
    ack_id      = 1'b0;
    if (cmd_rdy) begin
      ack_cmd = 1'b1;
      unique case (state)
        IDLE: begin
          if (cmd_d.op == OP_GO) begin
            dest_nxt  = cmd_d.stn;
            go_nxt    = 1'b1;
            state_nxt = MOVING;
          end
        end
        MOVING: begin
          if (cmd_d.op == OP_STOP) begin
            go_nxt    = 1'b0;
            state_nxt = IDLE;
          end else if (cmd_d.op == OP_GO) begin
            dest_nxt = cmd_d.stn;
          end
        end
        default: ;
      endcase
    end else if (ID_vld) begin
      ack_id = 1'b1;
      // IDs seen while idle are acknowledged and dropped.
      if (state == MOVING && ID[7:6] == 2'b00 && ID[5:0] == dest_ID) begin
        go_nxt      = 1'b0;
        arrived_nxt = 1'b1;
        state_nxt   = IDLE;
      end
    end
  end

  // Acks are suppressed while reset is held. This leaves any pending rdy/vld
  // for the controller to consume after reset is released.
  assign clr_cmd_rdy = rst_n & ack_cmd;
  assign clr_ID_vld  = rst_n & ack_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      go      <= 1'b0;
      dest_ID <= 6'h00;
      arrived <= 1'b0;
    end else begin
      state   <= state_nxt;
      go      <= go_nxt;
      dest_ID <= dest_nxt;
      arrived <= arrived_nxt;
    end
  end

`ifdef CMD_CNTRL_BUZZ_EN
  localparam int DIV_W = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV + 1) : 1;
  localparam int LEN_W = (BUZZ_LEN > 1) ? $clog2(BUZZ_LEN + 1) : 1;

  logic [LEN_W-1:0] len_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             buzz_q;
  logic             new_go;

  // Any accepted GO byte, in either state, silences the tone.
  assign new_go = cmd_rdy & (cmd_d.op == OP_GO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_cnt <= '0;
      div_cnt <= '0;
      buzz_q  <= 1'b0;
    end else if (new_go) begin
      len_cnt <= '0;
      div_cnt <= '0;
      buzz_q  <= 1'b0;
    end else if (arrived) begin
      // Start (or restart) the tone on its high half-period.
      len_cnt <= LEN_W'(BUZZ_LEN);
      div_cnt <= '0;
      buzz_q  <= 1'b1;
    end else if (len_cnt != '0) begin
      len_cnt <= len_cnt - 1'b1;
      if (len_cnt == LEN_W'(1)) begin
        div_cnt <= '0;
        buzz_q  <= 1'b0;
      end else if (div_cnt == DIV_W'(BUZZ_DIV - 1)) begin
        div_cnt <= '0;
        buzz_q  <= ~buzz_q;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end else begin
      buzz_q <= 1'b0;
    end
  end

  assign buzz   = buzz_q;
  assign buzz_n = ~buzz_q;
`else
  assign buzz   = 1'b0;
  assign buzz_n = 1'b1;
`endif

endmodule
